// File: rtl/wb_pkg.sv
// Shared definitions for the SimpleRisc writeback stage: opcodes, instruction
// field positions and the writeback FSM state type.
package wb_pkg;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RD_MSB  = 25;
  localparam int unsigned RD_LSB  = 22;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_class_decode.sv
// Combinational opcode classifier: does the instruction write the register
// file, and is it a load or a call (which pick a special data source/address).
module wb_class_decode
  import wb_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       writes,
  output logic       is_load,
  output logic       is_call
);

  always_comb begin
    writes  = 1'b0;
    is_load = 1'b0;
    is_call = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
      OP_AND, OP_OR, OP_NOT, OP_MOV,
      OP_LSL, OP_LSR, OP_ASR:               writes = 1'b1;
      OP_LD: begin
        writes  = 1'b1;
        is_load = 1'b1;
      end
      OP_CALL: begin
        writes  = 1'b1;
        is_call = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// SimpleRisc WB stage: drives the register-file write port, stalls on loads
// whose data has not arrived. Define WB_RETIRE_CNT_EN to add retire_count.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RA_IDX = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            is_wb,
  output logic [3:0]      wr_adr,
  output logic [XLEN-1:0] wr_data,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]     retire_count,
`endif
  output logic            spurious_rvalid
);

  wb_state_e  state;
  logic [3:0] ld_rd;
  logic [3:0] rd;
  logic       accept;
  logic       writes;
  logic       is_load;
  logic       is_call;
  logic       unused_instr_bits;

  assign rd                = in_instruction[RD_MSB:RD_LSB];
  assign in_ready          = (state == IDLE);
  assign accept            = in_valid && in_ready;
  assign unused_instr_bits = ^{in_instruction[26], in_instruction[21:0]};

  wb_class_decode u_decode (
    .opcode  (in_instruction[OPC_MSB:OPC_LSB]),
    .writes  (writes),
    .is_load (is_load),
    .is_call (is_call)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      is_wb           <= 1'b0;
      wr_adr          <= '0;
      wr_data         <= '0;
      spurious_rvalid <= 1'b0;
      ld_rd           <= '0;
    end else begin
      is_wb <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_load) begin
              if (mem_rvalid) begin
                is_wb   <= 1'b1;
                wr_adr  <= rd;
                wr_data <= mem_rdata;
              end else begin
                ld_rd <= rd;
                state <= WAIT_LD;
              end
            end else if (is_call) begin
              is_wb   <= 1'b1;
              wr_adr  <= 4'(RA_IDX);
              wr_data <= in_pc + XLEN'(4);
            end else if (writes) begin
              is_wb   <= 1'b1;
              wr_adr  <= rd;
              wr_data <= in_alu_result;
            end
          end
          // Load data with no load to consume it is dropped but remembered.
          if (mem_rvalid && !(accept && is_load))
            spurious_rvalid <= 1'b1;
        end
        WAIT_LD: begin
          if (mem_rvalid) begin
            is_wb   <= 1'b1;
            wr_adr  <= ld_rd;
            wr_data <= mem_rdata;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // A load retires when its data is captured, never at accept without data.
  logic retire;
  assign retire = (accept && (!is_load || mem_rvalid)) ||
                  ((state == WAIT_LD) && mem_rvalid);

  always_ff @(posedge clk) begin
    if (!reset)
      retire_count <= '0;
    else if (retire)
      retire_count <= retire_count + 32'd1;
  end
`endif

endmodule
